// File: rtl/ov7670_cfg_pkg.sv
// Shared types and ROM marker values for the OV7670 configuration sequencer.
// The ROM generator uses the same marker constants so both sides agree on the table format.
package ov7670_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        SEND   = 3'd3,
        WAIT   = 3'd4,
        DELAY  = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } cfg_state_t;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int cfg_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ov7670_config_sequencer_delay.sv
// Down-counter for FFF0 wait entries: load DELAY_CYCLES-1, decrement to zero, flag zero.
// The zero flag is registered alongside the count so it always matches the current value.
module cfg_delay_counter
    import ov7670_cfg_pkg::*;
#(
    parameter int DELAY_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = cfg_cnt_width(DELAY_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    // Next count: load wins over decrement, and the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        zero_d = (cnt_d == {CNT_W{1'b0}});
    end

    // Counter and zero-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CNT_W{1'b0}};
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and issues one SCCB write per entry, honouring FFF0/FFFF markers.
// Optional NACK retry is enabled with the OV7670_CFG_RETRY_EN macro.
module ov7670_config_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int DELAY_CYCLES = 240000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        rom_en,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        cmd_valid,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        cmd_ready,
    input  logic        cmd_done,
    input  logic        cmd_nack,
    output logic        busy,
    output logic        done,
    output logic        error
);

    cfg_state_t  state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic        rom_en_q, rom_en_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_reg_q, cmd_reg_d;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        dly_load_s;
    logic        dly_dec_s;
    logic        dly_zero_s;

`ifdef OV7670_CFG_RETRY_EN
    localparam int RTY_W = cfg_cnt_width(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);
    logic [RTY_W-1:0] retry_q, retry_d;
`endif

    cfg_delay_counter #(
        .DELAY_CYCLES (DELAY_CYCLES)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dly_load_s),
        .dec   (dly_dec_s),
        .zero  (dly_zero_s)
    );

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        cmd_reg_d  = cmd_reg_q;
        cmd_data_d = cmd_data_q;
        done_d     = done_q;
        error_d    = error_q;
        dly_load_s = 1'b0;
        dly_dec_s  = 1'b0;
`ifdef OV7670_CFG_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    rom_addr_d = 8'h00;
                    state_d    = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                if (rom_dout == CFG_END) begin
                    state_d = DONE;
                end else if (rom_dout == CFG_DELAY) begin
                    dly_load_s = 1'b1;
                    state_d    = DELAY;
                end else begin
                    cmd_reg_d  = rom_dout[15:8];
                    cmd_data_d = rom_dout[7:0];
`ifdef OV7670_CFG_RETRY_EN
                    retry_d    = {RTY_W{1'b0}};
`endif
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (cmd_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = SEND;
                end
            end
            WAIT: begin
                if (cmd_done) begin
`ifdef OV7670_CFG_RETRY_EN
                    // A NACK re-sends the latched reg/data without touching the ROM.
                    if (cmd_nack) begin
                        if (retry_q == RETRY_LIMIT) begin
                            error_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = SEND;
                        end
                    end else begin
                        state_d = NEXT;
                    end
`else
                    state_d = NEXT;
`endif
                end else begin
                    state_d = WAIT;
                end
            end
            DELAY: begin
                if (dly_zero_s) begin
                    state_d = NEXT;
                end else begin
                    dly_dec_s = 1'b1;
                    state_d   = DELAY;
                end
            end
            NEXT: begin
                // The last ROM slot ends the table even without an FFFF marker.
                if (rom_addr_q == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    state_d    = FETCH;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rom_en_d    = (state_d == FETCH);
        cmd_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rom_addr_q  <= 8'h00;
            rom_en_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_reg_q   <= 8'h00;
            cmd_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef OV7670_CFG_RETRY_EN
            retry_q     <= {RTY_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rom_en_q    <= rom_en_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef OV7670_CFG_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_reg   = cmd_reg_q;
    assign cmd_data  = cmd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench for ov7670_config_sequencer: ROM and SCCB slave models, vector table plus corner sequences.
// Retry scenarios run only when OV7670_CFG_RETRY_EN is defined.
`timescale 1ns/1ps
module tb_ov7670_config_sequencer;

    localparam int DLY = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        cmd_valid;
    logic [7:0]  cmd_reg;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        cmd_done;
    logic        cmd_nack;
    logic        busy;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] rom_mem [0:255];
    int          nack_limit = 0;

    int          cyc = 0;
    int          wr_count;
    logic [15:0] wr_log [0:511];
    int          dcnt;
    int          nacks_given;
    int          fetch_cyc [0:255];
    int          fetch0_cnt;
    int          done_cyc0;
    logic        done_seen0;

    typedef struct {
        int          kind;
        int          exp_wr;
        logic [7:0]  exp_addr;
        logic [15:0] exp_last;
    } vec_t;
    vec_t vecs [5];

    ov7670_config_sequencer #(.DELAY_CYCLES(DLY), .MAX_RETRY(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .cmd_valid (cmd_valid),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .cmd_done  (cmd_done),
        .cmd_nack  (cmd_nack),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Config ROM: registered output, updated only while rom_en is high.
    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_mem[rom_addr];
    end

    // SCCB slave: logs accepted writes, pulses cmd_done 3 cycles after accept, NACKs the first nack_limit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_done    <= 1'b0;
            cmd_nack    <= 1'b0;
            dcnt        <= 0;
            wr_count    <= 0;
            nacks_given <= 0;
            fetch0_cnt  <= 0;
            done_cyc0   <= 0;
            done_seen0  <= 1'b0;
        end else begin
            if (rom_en) begin
                fetch_cyc[rom_addr] <= cyc;
                if (rom_addr == 8'h00) fetch0_cnt <= fetch0_cnt + 1;
            end
            if (cmd_valid && cmd_ready) begin
                wr_log[wr_count[8:0]] <= {cmd_reg, cmd_data};
                wr_count <= wr_count + 1;
                dcnt     <= 3;
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1;
            end
            cmd_done <= (dcnt == 1);
            cmd_nack <= (dcnt == 1) && (nacks_given < nack_limit);
            if (dcnt == 1 && nacks_given < nack_limit) nacks_given <= nacks_given + 1;
            if (dcnt == 1 && !done_seen0) begin
                done_seen0 <= 1'b1;
                done_cyc0  <= cyc + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_rom(input int kind);
        for (int i = 0; i < 256; i++) rom_mem[i] = (kind == 2) ? 16'h1100 : 16'hFFFF;
        case (kind)
            0: begin rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1200; end
            3: begin rom_mem[0] = 16'hFFF0; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h3456; end
            4: begin rom_mem[0] = 16'hABCD; rom_mem[1] = 16'h0102; end
            5: begin rom_mem[0] = 16'h1280; end
            6: begin rom_mem[0] = 16'hFFF0; rom_mem[1] = 16'h1234; end
            7: begin rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1200; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    initial begin
        vecs[0] = '{0, 2,   8'h03, 16'h1200};
        vecs[1] = '{1, 0,   8'h00, 16'h0000};
        vecs[2] = '{2, 256, 8'hFF, 16'h1100};
        vecs[3] = '{3, 1,   8'h03, 16'h3456};
        vecs[4] = '{4, 2,   8'h02, 16'h0102};
        rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b1;

        // Reset state and start -> FETCH -> DECODE -> SEND latency.
        load_rom(5);
        do_reset();
        check("reset_outputs", {rom_en, rom_addr, cmd_valid, cmd_reg, cmd_data, busy, done, error}, 32'h0);
        pulse_start();
        check("fetch_cycle", {rom_en, busy, cmd_valid}, {29'd0, 3'b110});
        @(negedge clk);
        check("decode_cycle", {rom_en, cmd_valid}, 32'h0);
        @(negedge clk);
        check("send_cycle", {cmd_valid, cmd_reg, cmd_data}, {15'd0, 1'b1, 16'h1280});

        // Immediate FFFF: done rises 3 cycles after start is sampled.
        load_rom(1);
        do_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        check("ffff_pre_done", {done, busy}, 32'h1);
        @(negedge clk);
        check("ffff_done", {done, busy}, 32'h2);
        check("ffff_no_write", wr_count, 32'd0);

        // Vector table.
        for (int i = 0; i < 5; i++) begin
            load_rom(vecs[i].kind);
            do_reset();
            pulse_start();
            wait_done(5000, "table_done");
            check("table_busy", busy, 32'd0);
            check("table_error", error, 32'd0);
            check("table_addr", rom_addr, vecs[i].exp_addr);
            check("table_writes", wr_count, vecs[i].exp_wr);
            if (vecs[i].exp_wr > 0) check("table_last_wr", wr_log[vecs[i].exp_wr - 1], vecs[i].exp_last);
            check("table_no_wrap", fetch0_cnt, 32'd1);
            if (vecs[i].kind == 0) begin
                check("first_wr", wr_log[0], 32'h1280);
                check("delay_fetch_gap", fetch_cyc[2] - fetch_cyc[1], DLY + 3);
                check("done_to_fetch2", fetch_cyc[2] - done_cyc0, DLY + 5);
            end
        end

        // cmd_ready held low: request stays stable, single handshake.
        load_rom(5);
        do_reset();
        cmd_ready = 1'b0;
        pulse_start();
        for (int n = 0; n < 10 && cmd_valid !== 1'b1; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_stable", {cmd_valid, cmd_reg, cmd_data}, {15'd0, 1'b1, 16'h1280});
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        wait_done(100, "stall_done");
        check("stall_one_write", wr_count, 32'd1);

        // Start while busy is ignored; start while done restarts.
        load_rom(0);
        do_reset();
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_done(300, "busy_start_done");
        check("busy_start_fetch0", fetch0_cnt, 32'd1);
        check("busy_start_writes", wr_count, 32'd2);
        pulse_start();
        check("restart_clears", {done, busy}, 32'h1);
        wait_done(300, "restart_done");
        check("restart_writes", wr_count, 32'd4);

        // Reset in the middle of a delay, then a clean rerun.
        load_rom(6);
        do_reset();
        pulse_start();
        repeat (4) @(negedge clk);
        check("mid_delay_busy", busy, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_delay_reset", {rom_en, rom_addr, cmd_valid, cmd_reg, cmd_data, busy, done, error}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_done(300, "rerun_done");
        check("rerun_writes", wr_count, 32'd1);
        check("rerun_data", wr_log[0], 32'h1234);

`ifdef OV7670_CFG_RETRY_EN
        // Persistent NACK: four identical attempts, then error and done.
        load_rom(5);
        nack_limit = 100;
        do_reset();
        pulse_start();
        wait_done(300, "retry_all_done");
        check("retry_all_writes", wr_count, 32'd4);
        check("retry_all_same", {wr_log[1], wr_log[3]}, {16'h1280, 16'h1280});
        check("retry_all_error", error, 32'd1);
        // Single NACK: entry 0 twice, then the table continues.
        load_rom(7);
        nack_limit = 1;
        do_reset();
        pulse_start();
        wait_done(300, "retry_one_done");
        check("retry_one_writes", wr_count, 32'd3);
        check("retry_one_seq", {wr_log[1], wr_log[2]}, {16'h1280, 16'h1200});
        check("retry_one_error", error, 32'd0);
        nack_limit = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
